multi_switch: RTL and testbench
===============================

MULTI_SWITCH -- requirements
Module: multi_switch

Interface
REQ-001 Parameter CHANNELS, default 4, number of independent button/light channels (1..16).
REQ-002 Parameter DEBOUNCE, default 4, consecutive stable cycles required to accept a new button level (1..255).
REQ-003 Parameter TIMEOUT, default 16, on-time in cycles for TIMED mode (1..65535).
REQ-004 sClk  input  1  single clock; all state updates on its rising edge.
REQ-005 sReset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 sButton  input  CHANNELS  raw, asynchronous push-button levels, bit i = channel i.
REQ-007 sMode  input  2*CHANNELS  per-channel mode, bits [2i+1:2i] = channel i; synchronous to sClk.
REQ-008 sAllOff  input  1  synchronous global off request, active-high.
REQ-009 sLuz  output  CHANNELS  registered light outputs, bit i = channel i.
REQ-010 sPress  output  CHANNELS  registered one-cycle pulse per accepted debounced rising edge.

Function
REQ-011 Each sButton bit SHALL pass through a 2-flop synchroniser before any other logic.
REQ-012 Debounce: counter increments each cycle the synchronised level differs from the debounced level, clears when they match; the debounced level takes the new value on the cycle the counter reaches DEBOUNCE, and the counter clears.
REQ-013 A glitch shorter than DEBOUNCE cycles SHALL NOT change the debounced level, sPress or sLuz.
REQ-014 sPress[i] SHALL be high for exactly one cycle, on the cycle after the debounced level rises; falling edges produce no pulse.
REQ-015 Latency: sButton held at new level before edge 0 -> sPress and sLuz reflect it after edge DEBOUNCE+3.
REQ-016 Mode 00 TOGGLE: each press inverts sLuz[i].
REQ-017 Mode 01 MOMENTARY: sLuz[i] equals the debounced level, registered; it updates on the same edge sPress would rise or fall.
REQ-018 Mode 10 TIMED: press sets sLuz[i]=1 and loads the timer with TIMEOUT; timer decrements each cycle while nonzero; sLuz[i] clears on the edge the timer reaches 0, so on-time is exactly TIMEOUT cycles.
REQ-019 TIMED: a press while on reloads TIMEOUT (retrigger); a press on the same edge the timer expires keeps sLuz[i]=1 and reloads.
REQ-020 Mode 11 DISABLED: sLuz[i] held 0, timer held 0; sPress still generated.
REQ-021 Any change of sMode[i] SHALL clear sLuz[i] and the timer on the following edge; a press on that same edge is ignored.
REQ-022 sAllOff=1 SHALL clear all sLuz bits and timers on that edge, overriding every press and mode; debounce and sPress unaffected.
REQ-023 Channels SHALL be fully independent apart from sAllOff; simultaneous presses on all channels are all honoured.
REQ-024 Timer width SHALL be $clog2(TIMEOUT+1) bits; debounce counter $clog2(DEBOUNCE+1) bits; no wrap-around is permitted.

Reset
REQ-025 While sReset_n=0: sLuz=0, sPress=0, synchronisers=0, debounced levels=0, counters and timers=0, stored mode=00.
REQ-026 Reset asserted mid-operation (incl. active TIMED countdown) SHALL clear state immediately without waiting for sClk.
REQ-027 After sReset_n rises, a button already held high SHALL produce one press after DEBOUNCE+3 edges.

Structure
REQ-028 Package switch_pkg SHALL hold mode constants MODE_TOGGLE=2'b00, MODE_MOMENTARY=2'b01, MODE_TIMED=2'b10, MODE_DISABLED=2'b11.
REQ-029 Per-channel logic SHALL live in sub-module switch_channel (sync, debounce, edge detect, mode/timer), instantiated CHANNELS times by a generate loop.
REQ-030 Top level contains only instantiation and sAllOff fan-out; no shared state between channels.

Verification (CHANNELS=4, DEBOUNCE=4, TIMEOUT=16)
REQ-031 Toggle: ch0 mode 00, hold sButton[0]=1 for 10 cycles, release, repeat -> sPress[0] pulses at edge 7 each press; sLuz[0] goes 1 then 0.
REQ-032 Glitch: ch1 mode 00, sButton[1]=1 for 3 cycles -> sPress[1]=0, sLuz[1]=0 throughout.
REQ-033 Timed: ch2 mode 10, one press -> sLuz[2]=1 for exactly 16 cycles; second press at cycle 10 of on-time -> on-time extends to 26 cycles total.
REQ-034 Global off: ch0..ch3 lit (ch3 momentary, held), pulse sAllOff one cycle -> all sLuz=0 next edge; ch3 stays 0 until mode change or re-press.
REQ-035 Async reset: ch2 timed countdown at 8, drive sReset_n=0 between edges -> sLuz=0 immediately; release with sButton[2] held -> sLuz[2]=1 after 7 edges.
REQ-036 Mode change: ch0 lit in mode 00, switch sMode to 01 -> sLuz[0]=0 next edge, then follows debounced level.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared types for the multi-channel light switch: per-channel mode encoding.
package switch_pkg;

    typedef enum logic [1:0] {
        MODE_TOGGLE    = 2'b00,
        MODE_MOMENTARY = 2'b01,
        MODE_TIMED     = 2'b10,
        MODE_DISABLED  = 2'b11
    } mode_t;

endpackage

// File: rtl/multi_switch_if.sv
// Button/mode/light bundle between the switch block and its environment.
interface multi_switch_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]   sButton;
    logic [2*CHANNELS-1:0] sMode;
    logic                  sAllOff;
    logic [CHANNELS-1:0]   sLuz;
    logic [CHANNELS-1:0]   sPress;

    modport master (output sButton, sMode, sAllOff, input sLuz, sPress);
    modport slave  (input sButton, sMode, sAllOff, output sLuz, sPress);
endinterface

// File: rtl/switch_channel.sv
// One button/light channel: synchroniser, debounce, rising-edge press pulse,
// and the mode-dependent light/timer state.
module switch_channel
    import switch_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic       sClk,
    input  logic       sReset_n,
    input  logic       sButton,
    input  logic [1:0] sMode,
    input  logic       sAllOff,
    output logic       sLuz,
    output logic       sPress
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic          syncA, syncB;
    logic [CW-1:0] debCnt;
    logic          deb, debQ;
    logic          rise, change;
    logic          luzQ, pressQ;
    logic [TW-1:0] timerQ;
    mode_t         modeQ;

    assign rise   = deb & ~debQ;
    assign change = deb ^ debQ;
    assign sLuz   = luzQ;
    assign sPress = pressQ;

    // Two-flop synchroniser for the raw asynchronous button level.
    always_ff @(posedge sClk or negedge sReset_n) begin
        if (!sReset_n) begin
            syncA <= 1'b0;
            syncB <= 1'b0;
        end else begin
            syncA <= sButton;
            syncB <= syncA;
        end
    end

    // Debounce: the level must differ for DEBOUNCE counted cycles and still
    // differ when the count is full before it is accepted.
    always_ff @(posedge sClk or negedge sReset_n) begin
        if (!sReset_n) begin
            debCnt <= '0;
            deb    <= 1'b0;
        end else if (syncB == deb) begin
            debCnt <= '0;
        end else if (debCnt == CW'(DEBOUNCE)) begin
            deb    <= syncB;
            debCnt <= '0;
        end else begin
            debCnt <= debCnt + CW'(1);
        end
    end

    // Delayed debounced level and one-cycle press pulse on its rising edge.
    always_ff @(posedge sClk or negedge sReset_n) begin
        if (!sReset_n) begin
            debQ   <= 1'b0;
            pressQ <= 1'b0;
        end else begin
            debQ   <= deb;
            pressQ <= rise;
        end
    end

    // Light and timer: global off and mode changes clear first, then the
    // stored mode decides how a press (or level change) moves the light.
    always_ff @(posedge sClk or negedge sReset_n) begin
        if (!sReset_n) begin
            luzQ   <= 1'b0;
            timerQ <= '0;
            modeQ  <= MODE_TOGGLE;
        end else begin
            modeQ <= mode_t'(sMode);
            if (sAllOff || (sMode != modeQ)) begin
                luzQ   <= 1'b0;
                timerQ <= '0;
            end else begin
                case (modeQ)
                    MODE_TOGGLE: begin
                        timerQ <= '0;
                        if (rise) luzQ <= ~luzQ;
                    end
                    MODE_MOMENTARY: begin
                        // Edge-driven so a global off stays off while held.
                        timerQ <= '0;
                        if (change) luzQ <= deb;
                    end
                    MODE_TIMED: begin
                        if (rise) begin
                            luzQ   <= 1'b1;
                            timerQ <= TW'(TIMEOUT);
                        end else if (timerQ != '0) begin
                            timerQ <= timerQ - TW'(1);
                            if (timerQ == TW'(1)) luzQ <= 1'b0;
                        end
                    end
                    MODE_DISABLED: begin
                        luzQ   <= 1'b0;
                        timerQ <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/multi_switch.sv
// Multi-channel light switch: one independent switch_channel per button,
// with the global off request fanned out to every channel.
module multi_switch #(
    parameter int CHANNELS = 4,
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic           sClk,
    input  logic           sReset_n,
    multi_switch_if.slave  bus
);

    for (genvar i = 0; i < CHANNELS; i++) begin : gCh
        switch_channel #(
            .DEBOUNCE (DEBOUNCE),
            .TIMEOUT  (TIMEOUT)
        ) uCh (
            .sClk     (sClk),
            .sReset_n (sReset_n),
            .sButton  (bus.sButton[i]),
            .sMode    (bus.sMode[2*i+1:2*i]),
            .sAllOff  (bus.sAllOff),
            .sLuz     (bus.sLuz[i]),
            .sPress   (bus.sPress[i])
        );
    end

endmodule

// File: tb/tb_multi_switch.sv
// Directed bench for multi_switch (CHANNELS=4, DEBOUNCE=4, TIMEOUT=16).
// Inputs change 1 time unit after a rising edge; the next rising edge is
// "edge 0" of each pattern, and outputs are sampled 1 unit after each edge.
module tb_multi_switch;
    logic sClk = 1'b0;
    logic sReset_n;
    int   nTests = 0;
    int   nFail  = 0;

    multi_switch_if #(.CHANNELS(4)) bus ();

    multi_switch #(
        .CHANNELS (4),
        .DEBOUNCE (4),
        .TIMEOUT  (16)
    ) dut (
        .sClk     (sClk),
        .sReset_n (sReset_n),
        .bus      (bus)
    );

    always #5 sClk = ~sClk;

    task automatic step(input int n);
        repeat (n) @(posedge sClk);
        #1;
    endtask

    task automatic chk(input string tag, input int t, input logic [3:0] obs, input logic [3:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with buttons pressed: everything stays cleared.
        sReset_n    = 1'b0;
        bus.sButton = 4'hF;
        bus.sMode   = 8'b00_00_00_00;
        bus.sAllOff = 1'b0;
        step(3);
        chk("rst_luz", 0, bus.sLuz, 4'b0000);
        chk("rst_press", 0, bus.sPress, 4'b0000);
        bus.sButton = 4'h0;
        sReset_n    = 1'b1;
        step(3);

        // Toggle ch0: press held 10 cycles -> pulse at edge 7, light on.
        for (int t = 0; t < 22; t++) begin
            bus.sButton = (t <= 9) ? 4'b0001 : 4'b0000;
            step(1);
            chk("tog1_press", t, bus.sPress, (t == 7) ? 4'b0001 : 4'b0000);
            chk("tog1_luz", t, bus.sLuz, (t >= 7) ? 4'b0001 : 4'b0000);
        end
        // Second press turns it off again; release produced no pulse.
        for (int t = 0; t < 22; t++) begin
            bus.sButton = (t <= 9) ? 4'b0001 : 4'b0000;
            step(1);
            chk("tog2_press", t, bus.sPress, (t == 7) ? 4'b0001 : 4'b0000);
            chk("tog2_luz", t, bus.sLuz, (t >= 7) ? 4'b0000 : 4'b0001);
        end

        // Glitch on ch1 for 3 cycles is rejected.
        for (int t = 0; t < 16; t++) begin
            bus.sButton = (t <= 2) ? 4'b0010 : 4'b0000;
            step(1);
            chk("glitch_press", t, bus.sPress, 4'b0000);
            chk("glitch_luz", t, bus.sLuz, 4'b0000);
        end

        // Timed ch2: single press lights edges 7..22 (16 cycles).
        bus.sMode = 8'b00_10_00_00;
        step(2);
        for (int t = 0; t < 30; t++) begin
            bus.sButton = (t <= 9) ? 4'b0100 : 4'b0000;
            step(1);
            chk("timed_press", t, bus.sPress, (t == 7) ? 4'b0100 : 4'b0000);
            chk("timed_luz", t, bus.sLuz, (t >= 7 && t <= 22) ? 4'b0100 : 4'b0000);
        end
        step(4);

        // Retrigger: second press accepted at edge 17 (cycle 10 of on-time)
        // reloads, light stays on edges 7..32 (26 cycles).
        for (int t = 0; t < 40; t++) begin
            bus.sButton = ((t <= 4) || (t >= 10 && t <= 19)) ? 4'b0100 : 4'b0000;
            step(1);
            chk("retrig_press", t, bus.sPress, (t == 7 || t == 17) ? 4'b0100 : 4'b0000);
            chk("retrig_luz", t, bus.sLuz, (t >= 7 && t <= 32) ? 4'b0100 : 4'b0000);
        end
        step(4);

        // Global off: all four pressed together, ch3 momentary and held.
        bus.sMode = 8'b01_10_00_00;
        step(2);
        for (int t = 0; t < 26; t++) begin
            bus.sButton = (t <= 9) ? 4'b1111 : 4'b1000;
            bus.sAllOff = (t == 9);
            step(1);
            chk("alloff_press", t, bus.sPress, (t == 7) ? 4'b1111 : 4'b0000);
            chk("alloff_luz", t, bus.sLuz, (t >= 7 && t <= 8) ? 4'b1111 : 4'b0000);
        end
        bus.sAllOff = 1'b0;
        for (int t = 0; t < 10; t++) begin
            bus.sButton = 4'b0000;
            step(1);
            chk("alloff_rel_press", t, bus.sPress, 4'b0000);
            chk("alloff_rel_luz", t, bus.sLuz, 4'b0000);
        end

        // Mode change: light ch0 in toggle mode, then switch ch0 to
        // momentary (and ch1 to disabled).
        for (int t = 0; t < 22; t++) begin
            bus.sButton = (t <= 4) ? 4'b0001 : 4'b0000;
            step(1);
            chk("mc_lit_luz", t, bus.sLuz, (t >= 7) ? 4'b0001 : 4'b0000);
        end
        bus.sMode = 8'b01_10_11_01;
        step(1);
        chk("mc_clear_luz", 0, bus.sLuz, 4'b0000);
        for (int t = 0; t < 22; t++) begin
            bus.sButton = (t <= 9) ? 4'b0011 : 4'b0000;
            step(1);
            chk("mc_mom_press", t, bus.sPress, (t == 7) ? 4'b0011 : 4'b0000);
            chk("mc_mom_luz", t, bus.sLuz, (t >= 7 && t <= 16) ? 4'b0001 : 4'b0000);
        end
        step(4);

        // Async reset in the middle of a timed countdown (timer at 8).
        for (int t = 0; t < 16; t++) begin
            bus.sButton = 4'b0100;
            step(1);
            chk("ar_luz", t, bus.sLuz, (t >= 7) ? 4'b0100 : 4'b0000);
        end
        #2;
        sReset_n = 1'b0;
        #1;
        chk("ar_immediate_luz", 0, bus.sLuz, 4'b0000);
        chk("ar_immediate_press", 0, bus.sPress, 4'b0000);
        step(2);
        chk("ar_held_luz", 0, bus.sLuz, 4'b0000);
        sReset_n = 1'b1;
        // Button still held: one press and light at edge 7 after release.
        for (int t = 0; t < 10; t++) begin
            step(1);
            chk("ar_rel_press", t, bus.sPress, (t == 7) ? 4'b0100 : 4'b0000);
            chk("ar_rel_luz", t, bus.sLuz, (t >= 7) ? 4'b0100 : 4'b0000);
        end
        bus.sButton = 4'b0000;
        step(2);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
